// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg
//   Shared definitions for the instruction-memory responder slice:
//   FSM state encoding, wait-counter width, instruction word width and a
//   helper that turns the integer wait-state parameter into a counter value.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  localparam int WAIT_WIDTH = 4;
  localparam int INSTR_W    = 32;

  // Counter load value for a fresh access.
  function automatic logic [WAIT_WIDTH-1:0] wait_load(input int ws);
    return WAIT_WIDTH'(ws);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if
//   Fetch/loader bus between the instruction fetch unit (plus boot loader)
//   and the instruction-memory responder.
//   master : drives address, wr_en, wr_addr, wr_data; sees instruction,
//            inst_valid, stall
//   slave  : the responder side of the same signals
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic [31:0]        address;      // byte fetch address, bits [1:0] unused
  logic               wr_en;        // loader write strobe
  logic [29:0]        wr_addr;      // loader word address
  logic [INSTR_W-1:0] wr_data;      // loader write data
  logic [INSTR_W-1:0] instruction;  // fetched word (registered)
  logic               inst_valid;   // instruction belongs to current address
  logic               stall;        // IFU stall, always ~inst_valid

  modport master (
    output address, wr_en, wr_addr, wr_data,
    input  instruction, inst_valid, stall
  );

  modport slave (
    input  address, wr_en, wr_addr, wr_data,
    output instruction, inst_valid, stall
  );

endinterface

// File: rtl/imem_array.sv
// imem_array
//   DEPTH x INSTR_W program storage: synchronous write, asynchronous read.
//   Contents are not reset.
//   clock   : write clock (rising edge)
//   i_we    : write enable
//   i_waddr : write word index
//   i_wdata : write data
//   i_raddr : read word index
//   o_rdata : read data (combinational)
module imem_array
  import imem_responder_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               i_we,
  input  logic [IW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [IW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder. Tracks the IFU fetch address, spends
//   WAIT_STATES extra cycles per access, then presents the registered
//   instruction with inst_valid while the address stays on that word.
//   A changed address restarts the access; a loader write that hits the word
//   being fetched also restarts it so the fresh data is returned.
//   clock : rising-edge clock
//   start : asynchronous active-low reset
//   bus   : imem_responder_if.slave (address, loader write port,
//           instruction, inst_valid, stall)
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              start,
  imem_responder_if.slave   bus
);

  localparam int                    IW      = $clog2(DEPTH);
  localparam logic [WAIT_WIDTH-1:0] WS_LOAD = wait_load(WAIT_STATES);

  state_t                r_state, w_state_nxt;
  logic [29:0]           r_tag, w_tag_nxt;
  logic [WAIT_WIDTH-1:0] r_count, w_count_nxt;
  logic [INSTR_W-1:0]    r_instr, w_instr_nxt;

  logic [29:0]           w_word;
  logic [IW-1:0]         w_word_idx;
  logic [IW-1:0]         w_wr_idx;
  logic                  w_match;
  logic                  w_coh;
  logic                  w_hit;
  logic                  w_start_acc;
  logic [INSTR_W-1:0]    w_rdata;
  logic [INSTR_W-1:0]    w_fill;
  logic                  w_unused;

  assign w_word     = bus.address[31:2];
  assign w_word_idx = w_word[IW-1:0];
  assign w_wr_idx   = bus.wr_addr[IW-1:0];
  assign w_match    = (w_word == r_tag);
  // Coherence is judged on the storage index, since aliased addresses share it.
  assign w_coh      = bus.wr_en && (w_wr_idx == r_tag[IW-1:0]);
  assign w_hit      = (r_state == ST_READY) && w_match;
  // Zero-wait fills read the array in the same cycle a write may land on the
  // same word; forward the write data so the new value is returned.
  assign w_fill     = (bus.wr_en && (w_wr_idx == w_word_idx)) ? bus.wr_data : w_rdata;
  assign w_unused   = ^{bus.address[1:0], bus.wr_addr[29:IW]};

  // The array is always read at the current fetch word: an access only
  // completes while the address still equals the tag.
  imem_array #(.DEPTH(DEPTH)) u_array (
    .clock   (clock),
    .i_we    (bus.wr_en),
    .i_waddr (w_wr_idx),
    .i_wdata (bus.wr_data),
    .i_raddr (w_word_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      r_state <= ST_IDLE;
      r_tag   <= '0;
      r_count <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      r_count <= w_count_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tag_nxt   = r_tag;
    w_count_nxt = r_count;
    w_instr_nxt = r_instr;
    w_start_acc = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_start_acc = 1'b1;
      end
      ST_ACCESS: begin
        // Address moved or our word was rewritten: drop the partial access.
        if (!w_match || w_coh) begin
          w_start_acc = 1'b1;
        end else if (r_count == WAIT_WIDTH'(1)) begin
          w_instr_nxt = w_rdata;
          w_state_nxt = ST_READY;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      ST_READY: begin
        if (!w_match || w_coh) begin
          w_start_acc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_start_acc) begin
      w_tag_nxt = w_word;
      if (WAIT_STATES == 0) begin
        w_state_nxt = ST_READY;
        w_count_nxt = '0;
        w_instr_nxt = w_fill;
      end else begin
        w_state_nxt = ST_ACCESS;
        w_count_nxt = WS_LOAD;
      end
    end
  end

  assign bus.instruction = r_instr;
  assign bus.inst_valid  = w_hit;
  assign bus.stall       = ~w_hit;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Drives two responders (WAIT_STATES=2 and WAIT_STATES=0) with the same
//   fetch/loader stimulus. A reference model predicts, per cycle, whether the
//   instruction is valid and which word it must be, from how long the fetch
//   word has been held since its last (re)start; predictions go into
//   per-DUT queues that a separate monitor drains and compares.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int IW    = 10;
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;

  typedef struct {
    logic               valid;
    logic               zero;
    logic [INSTR_W-1:0] instr;
    int                 cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if if_a ();
  imem_responder_if if_b ();

  imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_a (
    .clock (clk),
    .start (start),
    .bus   (if_a)
  );

  imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_b (
    .clock (clk),
    .start (start),
    .bus   (if_b)
  );

  exp_t               qa[$];
  exp_t               qb[$];
  logic [INSTR_W-1:0] mmem [DEPTH];
  bit                 m_idle  [2];
  logic [29:0]        m_word  [2];
  int                 m_start [2];
  int                 cyc;
  int                 total;
  int                 bad;

  // Reference: a word is valid once it has been held, unbroken by a restart,
  // for 1+ws cycles. A restart is leaving reset, a new word, or a loader
  // write to the storage index of the word being fetched.
  task automatic model_dut(input int d, input int ws, input logic [29:0] aw,
                           input logic we, input logic [29:0] wa, output exp_t e);
    e.zero  = !start;
    e.valid = start && !m_idle[d] && (aw == m_word[d]) && ((cyc - m_start[d]) >= 1 + ws);
    e.instr = mmem[aw[IW-1:0]];
    e.cyc   = cyc;
    if (!start) begin
      m_idle[d] = 1'b1;
    end else if (m_idle[d] || (aw != m_word[d]) || (we && (wa[IW-1:0] == m_word[d][IW-1:0]))) begin
      m_idle[d]  = 1'b0;
      m_word[d]  = aw;
      m_start[d] = cyc;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [29:0] wa,
                       input logic [31:0] wd, input logic rs);
    exp_t ea;
    exp_t eb;
    @(negedge clk);
    start        = rs;
    if_a.address = a;  if_a.wr_en = we;  if_a.wr_addr = wa;  if_a.wr_data = wd;
    if_b.address = a;  if_b.wr_en = we;  if_b.wr_addr = wa;  if_b.wr_data = wd;
    model_dut(0, WS_A, a[31:2], we, wa, ea);
    model_dut(1, WS_B, a[31:2], we, wa, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    if (we) mmem[wa[IW-1:0]] = wd;
    cyc++;
  endtask

  task automatic fetch(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) drive(a, 1'b0, 30'h0, 32'h0, 1'b1);
  endtask

  task automatic check_item(input string nm, input exp_t e, input logic v,
                            input logic s, input logic [31:0] ins);
    logic [31:0] want;
    total++;
    if (v !== e.valid) begin
      bad++;
      $display("FAIL %s inst_valid cyc=%0d got=%0b want=%0b", nm, e.cyc, v, e.valid);
    end
    total++;
    if (s !== ~e.valid) begin
      bad++;
      $display("FAIL %s stall cyc=%0d got=%0b want=%0b", nm, e.cyc, s, ~e.valid);
    end
    if (e.valid || e.zero) begin
      want = e.zero ? 32'h0 : e.instr;
      total++;
      if (ins !== want) begin
        bad++;
        $display("FAIL %s instruction cyc=%0d got=%08h want=%08h", nm, e.cyc, ins, want);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (qa.size() > 0) check_item("ws2", qa.pop_front(), if_a.inst_valid, if_a.stall, if_a.instruction);
      while (qb.size() > 0) check_item("ws0", qb.pop_front(), if_b.inst_valid, if_b.stall, if_b.instruction);
    end
  end

  initial begin
    logic [7:0]  pat;
    logic [31:0] a;
    logic [29:0] wa;
    logic        we;
    logic        rs;
    int          hold;

    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    for (int d = 0; d < 2; d++) begin
      m_idle[d] = 1'b1; m_word[d] = '0; m_start[d] = 0;
    end
    if_a.address = '0; if_a.wr_en = 1'b0; if_a.wr_addr = '0; if_a.wr_data = '0;
    if_b.address = '0; if_b.wr_en = 1'b0; if_b.wr_addr = '0; if_b.wr_data = '0;

    // Reset, then fill the program memory (index 0 first, at the fetched word).
    drive(32'h0, 1'b0, 30'h0, 32'h0, 1'b0);
    drive(32'h0, 1'b0, 30'h0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i == 0) v = 32'h2000_0001;
      if (i == 1) v = 32'h2000_0002;
      drive(32'h0, 1'b1, 30'(i), v, 1'b1);
    end

    // Sequential fetch 0x0, 0x4 with a stall pattern check on the WS=2 unit.
    fetch(32'h100, 2);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      drive((i < 4) ? 32'h0 : 32'h4, 1'b0, 30'h0, 32'h0, 1'b1);
      #1 pat = {pat[6:0], if_a.stall};
    end
    total++;
    if (pat !== 8'b1110_1110) begin
      bad++;
      $display("FAIL stall_pattern got=%b want=%b", pat, 8'b1110_1110);
    end

    // Reset in the middle of an access, then fetch 0x0.
    fetch(32'h8, 2);
    drive(32'h8, 1'b0, 30'h0, 32'h0, 1'b0);
    fetch(32'h0, 5);

    // Abort: 0x8 replaced by 0x40 one cycle into the access.
    fetch(32'h100, 3);
    fetch(32'h8, 2);
    fetch(32'h40, 5);

    // Coherent write to the word in READY, then a write elsewhere.
    fetch(32'h10, 5);
    drive(32'h10, 1'b1, 30'd4, 32'hDEAD_BEEF, 1'b1);
    fetch(32'h10, 5);
    drive(32'h10, 1'b1, 30'd5, 32'h1234_5678, 1'b1);
    fetch(32'h10, 1);
    #1;
    total++;
    if (if_a.inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL noncoherent_write inst_valid got=%0b want=1", if_a.inst_valid);
    end

    // Wrap-around: word 0x400 aliases index 0.
    fetch(32'h1000, 5);

    // Randomised phase: short address runs, loader traffic, occasional reset.
    for (int n = 0; n < 600; n++) begin
      a    = {(($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0),
              10'($urandom_range(0, 15)), 2'($urandom)};
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        rs = ($urandom_range(0, 80) != 0);
        we = rs && ($urandom_range(0, 4) == 0);
        wa = {(($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0),
              10'($urandom_range(0, 15))};
        drive(a, we, wa, $urandom, rs);
      end
    end

    drive(32'h0, 1'b0, 30'h0, 32'h0, 1'b1);
    @(negedge clk);
    #4;
    total++;
    if ((qa.size() != 0) || (qb.size() != 0)) begin
      bad++;
      $display("FAIL queue_drain got=%0d/%0d want=0/0", qa.size(), qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
